// File: rtl/pio_latency_probe.sv
// pio_latency_probe: HPS <-> fabric round-trip latency engine.
// An HPS start toggle makes the block flip ping_tgl and count fabric cycles
// until the HPS flips its echo toggle; the count is then recorded as the last
// latency together with running min/max/sample-count statistics.
//
// Ports:
//   clk, reset_n      fabric clock, asynchronous active-low reset
//   cmd_word          [31] start_tgl, [30] echo_tgl, [29] clear (level),
//                     [28:24] ignored, [23:0] timeout in cycles (0 = none)
//   status_word       [31] ping_tgl, [30] busy, [29] done, [28] timeout_flag,
//                     [27:16] sample_count[11:0], [15:0] zero
//   result_word       last captured latency
//   min_word/max_word minimum / maximum captured latency
//   sample_count      number of successful captures (saturating)
//   done_pulse        one-cycle strobe on each capture
//   sum_lo/sum_hi     48-bit saturating latency accumulator, present only
//                     when PIO_LAT_SUM_EN is defined
module pio_latency_probe #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned TMO_W  = 24,
  parameter int unsigned SCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       cmd_word,
  output logic [31:0]       status_word,
  output logic [CNT_W-1:0]  result_word,
  output logic [CNT_W-1:0]  min_word,
  output logic [CNT_W-1:0]  max_word,
  output logic [SCNT_W-1:0] sample_count,
  output logic              done_pulse
`ifdef PIO_LAT_SUM_EN
  ,
  output logic [31:0]       sum_lo,
  output logic [15:0]       sum_hi
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_TMO     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             start_prev_q, echo_prev_q;
  logic             ping_q, busy_q, done_q, tflag_q;
  logic [CNT_W-1:0] cnt_q;

  logic             start_edge_c, echo_edge_c, clear_c, tmo_hit_c;
  logic             start_go_c, cap_go_c, tmo_go_c, cnt_inc_c;
  logic [TMO_W-1:0] tmo_c;
  logic             unused_cmd_c;

  // Command decode; toggles are compared against last cycle's copy.
  assign start_edge_c = cmd_word[31] ^ start_prev_q;
  assign echo_edge_c  = cmd_word[30] ^ echo_prev_q;
  assign clear_c      = cmd_word[29];
  assign tmo_c        = cmd_word[TMO_W-1:0];
  assign tmo_hit_c    = (tmo_c != '0) && (cnt_q == CNT_W'(tmo_c));
  assign unused_cmd_c = ^cmd_word[28:24];

  assign status_word = {ping_q, busy_q, done_q, tflag_q, 12'(sample_count), 16'h0000};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and datapath strobes; clear dominates every edge.
  always_comb begin
    state_d    = state_q;
    start_go_c = 1'b0;
    cap_go_c   = 1'b0;
    tmo_go_c   = 1'b0;
    cnt_inc_c  = 1'b0;
    if (clear_c) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_edge_c) begin
            state_d    = ST_WAIT;
            start_go_c = 1'b1;
          end
        end
        ST_WAIT: begin
          // Echo beats a same-cycle timeout; cnt freezes on exit so CAPTURE sees the sampled value.
          if (echo_edge_c)    state_d = ST_CAPTURE;
          else if (tmo_hit_c) state_d = ST_TMO;
          else                cnt_inc_c = 1'b1;
        end
        ST_CAPTURE: begin
          state_d  = ST_IDLE;
          cap_go_c = 1'b1;
        end
        ST_TMO: begin
          state_d  = ST_IDLE;
          tmo_go_c = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Toggle history, counter, flags and statistics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_prev_q <= 1'b0;
      echo_prev_q  <= 1'b0;
      ping_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tflag_q      <= 1'b0;
      cnt_q        <= '0;
      result_word  <= '0;
      min_word     <= '1;
      max_word     <= '0;
      sample_count <= '0;
      done_pulse   <= 1'b0;
    end else begin
      start_prev_q <= cmd_word[31];
      echo_prev_q  <= cmd_word[30];
      done_pulse   <= 1'b0;
      if (clear_c) begin
        // ping_q deliberately survives so the HPS keeps its toggle parity.
        busy_q       <= 1'b0;
        done_q       <= 1'b0;
        tflag_q      <= 1'b0;
        cnt_q        <= '0;
        result_word  <= '0;
        min_word     <= '1;
        max_word     <= '0;
        sample_count <= '0;
      end else begin
        if (start_go_c) begin
          ping_q  <= ~ping_q;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          tflag_q <= 1'b0;
          cnt_q   <= '0;
        end
        if (cnt_inc_c && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
        if (cap_go_c) begin
          result_word <= cnt_q;
          if (cnt_q < min_word) min_word <= cnt_q;
          if (cnt_q > max_word) max_word <= cnt_q;
          if (sample_count != '1) sample_count <= sample_count + SCNT_W'(1);
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          done_pulse <= 1'b1;
        end
        if (tmo_go_c) begin
          tflag_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      end
    end
  end

`ifdef PIO_LAT_SUM_EN
  logic [47:0] sum_q;
  logic [48:0] sum_next_c;

  assign sum_next_c = {1'b0, sum_q} + 49'(cnt_q);
  assign sum_lo     = sum_q[31:0];
  assign sum_hi     = sum_q[47:32];

  // Saturating accumulator of every captured latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      sum_q <= '0;
    else if (clear_c)  sum_q <= '0;
    else if (cap_go_c) sum_q <= sum_next_c[48] ? '1 : sum_next_c[47:0];
  end
`else
  // Accumulator not built in this configuration.
`endif

endmodule

// File: tb/tb_pio_latency_probe.sv
// Directed bench for pio_latency_probe with a result scoreboard.
module tb_pio_latency_probe;

  logic        clk;
  logic        reset_n;
  logic        start_tgl, echo_tgl, clr;
  logic [23:0] tmo;
  logic [31:0] cmd_word;
  logic [31:0] status_word;
  logic [31:0] result_word, min_word, max_word;
  logic [15:0] sample_count;
  logic        done_pulse;
`ifdef PIO_LAT_SUM_EN
  logic [31:0] sum_lo;
  logic [15:0] sum_hi;
`endif

  int vectors = 0;
  int errors  = 0;
  int sb[$];

  assign cmd_word = {start_tgl, echo_tgl, clr, 5'b00000, tmo};

  pio_latency_probe dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_word     (cmd_word),
    .status_word  (status_word),
    .result_word  (result_word),
    .min_word     (min_word),
    .max_word     (max_word),
    .sample_count (sample_count),
    .done_pulse   (done_pulse)
`ifdef PIO_LAT_SUM_EN
    ,
    .sum_lo       (sum_lo),
    .sum_hi       (sum_hi)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each capture strobe must match the oldest outstanding echo latency.
  always @(negedge clk) begin
    if (reset_n && done_pulse) begin
      if (sb.size() == 0) begin
        check("unexpected_done_pulse", 64'd1, 64'd0);
      end else begin
        int e;
        e = sb.pop_front();
        check("sb_result", result_word, e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start a measurement and answer k cycles after ping_tgl changes.
  task automatic run_echo(input int k);
    logic p;
    p = ~status_word[31];
    start_tgl = ~start_tgl;
    tick(1);
    check("ping_toggled", status_word[31], p);
    check("busy_set", status_word[30], 1'b1);
    tick(k);
    echo_tgl = ~echo_tgl;
    sb.push_back(k);
    tick(4);
  endtask

  initial begin
    logic p;
    reset_n = 1'b0; start_tgl = 1'b0; echo_tgl = 1'b0; clr = 1'b0; tmo = '0;
    tick(3);
    check("rst_status", status_word, 32'h0);
    check("rst_result", result_word, 32'h0);
    check("rst_min", min_word, 32'hFFFF_FFFF);
    check("rst_max", max_word, 32'h0);
    check("rst_count", sample_count, 16'h0);
    check("rst_pulse", done_pulse, 1'b0);
    reset_n = 1'b1;
    tick(2);

    // Single run, echo at 10.
    run_echo(10);
    check("r1_result", result_word, 32'd10);
    check("r1_min", min_word, 32'd10);
    check("r1_max", max_word, 32'd10);
    check("r1_count", sample_count, 16'd1);
    check("r1_done", status_word[29], 1'b1);
    check("r1_busy", status_word[30], 1'b0);

    // Clear, then three runs.
    clr = 1'b1; tick(1); clr = 1'b0;
    check("clr_min", min_word, 32'hFFFF_FFFF);
    check("clr_count", sample_count, 16'd0);
    run_echo(5);
    run_echo(20);
    run_echo(12);
    check("r3_result", result_word, 32'd12);
    check("r3_min", min_word, 32'd5);
    check("r3_max", max_word, 32'd20);
    check("r3_count", sample_count, 16'd3);
    check("r3_status_cnt", status_word[27:16], 12'd3);

    // Timeout of 8 with no echo.
    tmo = 24'd8;
    start_tgl = ~start_tgl;
    tick(14);
    check("tmo_flag", status_word[28], 1'b1);
    check("tmo_busy", status_word[30], 1'b0);
    check("tmo_done", status_word[29], 1'b0);
    check("tmo_result", result_word, 32'd12);
    check("tmo_min", min_word, 32'd5);
    check("tmo_max", max_word, 32'd20);
    check("tmo_count", sample_count, 16'd3);
    run_echo(4);
    check("post_tmo_result", result_word, 32'd4);
    check("post_tmo_flag", status_word[28], 1'b0);
    check("post_tmo_min", min_word, 32'd4);

    // Echo and timeout on the same cycle: echo wins.
    tmo = 24'd6;
    run_echo(6);
    check("tie_result", result_word, 32'd6);
    check("tie_flag", status_word[28], 1'b0);
    check("tie_count", sample_count, 16'd5);
    tmo = 24'd0;

    // Start edge during WAIT is ignored.
    p = ~status_word[31];
    start_tgl = ~start_tgl;
    tick(1);
    start_tgl = ~start_tgl;
    tick(15);
    check("wait_start_ping", status_word[31], p);
    check("wait_start_busy", status_word[30], 1'b1);
    echo_tgl = ~echo_tgl;
    sb.push_back(15);
    tick(4);
    check("wait_start_result", result_word, 32'd15);
    check("wait_start_count", sample_count, 16'd6);

    // Echo edge in IDLE is ignored.
    p = status_word[31];
    echo_tgl = ~echo_tgl;
    tick(5);
    check("idle_echo_busy", status_word[30], 1'b0);
    check("idle_echo_count", sample_count, 16'd6);
    check("idle_echo_ping", status_word[31], p);

    // Clear in the middle of WAIT.
    start_tgl = ~start_tgl;
    tick(1);
    p = status_word[31];
    tick(3);
    clr = 1'b1;
    tick(1);
    check("mid_clr_busy", status_word[30], 1'b0);
    check("mid_clr_min", min_word, 32'hFFFF_FFFF);
    check("mid_clr_max", max_word, 32'h0);
    check("mid_clr_count", sample_count, 16'd0);
    check("mid_clr_result", result_word, 32'h0);
    check("mid_clr_ping", status_word[31], p);
    clr = 1'b0;
    echo_tgl = ~echo_tgl;
    tick(5);
    check("late_echo_done", status_word[29], 1'b0);
    check("late_echo_count", sample_count, 16'd0);
    check("late_echo_busy", status_word[30], 1'b0);

`ifdef PIO_LAT_SUM_EN
    run_echo(100);
    run_echo(300);
    check("sum_lo", sum_lo, 32'd400);
    check("sum_hi", sum_hi, 16'd0);
`endif

    tick(2);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
